// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: one 16-bit Galois LFSR whose words are handed out one at a time
// to NUM_REQ requesters. A round-robin arbiter picks the requester.
// The block has a warm-up phase, accepts a new seed, and recovers if the LFSR ever reaches zero.
module lfsr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter logic [15:0] SEED    = 16'h4575,
    parameter int unsigned WARMUP  = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               enable_in,
    input  logic               seed_valid_in,
    input  logic [15:0]        seed_in,
    input  logic [NUM_REQ-1:0] req_in,
    output logic [NUM_REQ-1:0] grant_out,
    output logic               valid_out,
    output logic [15:0]        data_out,
    output logic               busy_out,
    output logic [15:0]        served_out
);

    localparam int unsigned LFSR_W    = 16;
    localparam int unsigned CNT_W     = 16;
    localparam int unsigned PTR_W     = $clog2(NUM_REQ);
    localparam logic [LFSR_W-1:0] TAPS = 16'h8005;
    localparam logic [CNT_W-1:0] WARM_LAST = (WARMUP == 0) ? CNT_W'(0) : CNT_W'(WARMUP - 1);

    typedef enum logic {
        ST_WARMUP = 1'b0,
        ST_SERVE  = 1'b1
    } state_e;

    // A seed load or a reset goes straight to SERVE when no warm-up is configured
    localparam state_e ST_INIT = (WARMUP == 0) ? ST_SERVE : ST_WARMUP;

    state_e              state_q, state_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic                valid_q, valid_d;
    logic [LFSR_W-1:0]   data_q, data_d;
    logic                busy_q, busy_d;
    logic [15:0]         served_q, served_d;

    logic                win_found_c;
    logic [PTR_W-1:0]    win_idx_c;
    logic [PTR_W-1:0]    cand_c;

    // One Galois step: shift left and fold bit 15 back into taps 15, 2 and 0
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] q);
        lfsr_step = {q[14:0], 1'b0} ^ (q[15] ? TAPS : LFSR_W'(0));
    endfunction

    // Round-robin search: the first active request at or after the pointer wins
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
        cand_c      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand_c = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!win_found_c && req_in[cand_c]) begin
                win_found_c = 1'b1;
                win_idx_c   = cand_c;
            end
        end
    end

    // Next-state logic. Order of priority: seed load, zero lock-up recovery, then a normal enabled step.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        grant_d  = '0;
        valid_d  = 1'b0;
        data_d   = data_q;
        served_d = served_q;

        if (seed_valid_in) begin
            lfsr_d  = (seed_in == '0) ? SEED : seed_in;
            cnt_d   = '0;
            state_d = ST_INIT;
        end else if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end else if (enable_in) begin
            lfsr_d = lfsr_step(lfsr_q);
            case (state_q)
                ST_WARMUP: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == WARM_LAST) begin
                        state_d = ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (win_found_c) begin
                        grant_d  = NUM_REQ'(1) << win_idx_c;
                        valid_d  = 1'b1;
                        data_d   = lfsr_q;
                        served_d = served_q + 16'd1;
                        ptr_d    = (win_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_c + PTR_W'(1);
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end

        busy_d = (state_d == ST_WARMUP);
    end

    // State and output registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= ST_INIT;
            lfsr_q   <= SEED;
            cnt_q    <= '0;
            ptr_q    <= '0;
            grant_q  <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            busy_q   <= (ST_INIT == ST_WARMUP);
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            served_q <= served_d;
        end
    end

    assign grant_out  = grant_q;
    assign valid_out  = valid_q;
    assign data_out   = data_q;
    assign busy_out   = busy_q;
    assign served_out = served_q;

endmodule

// File: tb/tb_lfsr_arbiter.sv
// Bench for lfsr_arbiter. Instance A has no warm-up and is driven from a table of vectors.
// Instance B has a 16-cycle warm-up and is driven by hand-written sequences.
module tb_lfsr_arbiter;

    logic clk;

    logic        a_rst_n, a_en, a_sv;
    logic [15:0] a_seed;
    logic [3:0]  a_req;
    logic [3:0]  a_grant;
    logic        a_valid, a_busy;
    logic [15:0] a_data, a_served;

    logic        b_rst_n, b_en, b_sv;
    logic [15:0] b_seed;
    logic [3:0]  b_req;
    logic [3:0]  b_grant;
    logic        b_valid, b_busy;
    logic [15:0] b_data, b_served;

    int checks;
    int failures;

    lfsr_arbiter #(.NUM_REQ(4), .SEED(16'h4575), .WARMUP(0)) dut_a (
        .clk_in(clk), .rst_n_in(a_rst_n), .enable_in(a_en), .seed_valid_in(a_sv),
        .seed_in(a_seed), .req_in(a_req), .grant_out(a_grant), .valid_out(a_valid),
        .data_out(a_data), .busy_out(a_busy), .served_out(a_served)
    );

    lfsr_arbiter #(.NUM_REQ(4), .SEED(16'h4575), .WARMUP(16)) dut_b (
        .clk_in(clk), .rst_n_in(b_rst_n), .enable_in(b_en), .seed_valid_in(b_sv),
        .seed_in(b_seed), .req_in(b_req), .grant_out(b_grant), .valid_out(b_valid),
        .data_out(b_data), .busy_out(b_busy), .served_out(b_served)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        sv;
        logic [15:0] seed;
        logic [3:0]  req;
        logic [3:0]  grant;
        logic        valid;
        logic [15:0] data;
        logic [15:0] served;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic en, input logic sv, input logic [15:0] seed,
                                input logic [3:0] req, input logic [3:0] g, input logic v,
                                input logic [15:0] d, input logic [15:0] s);
        vec_t r;
        r.en = en; r.sv = sv; r.seed = seed; r.req = req;
        r.grant = g; r.valid = v; r.data = d; r.served = s;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        a_rst_n = 1'b0; a_en = 1'b0; a_sv = 1'b0; a_seed = '0; a_req = '0;
        b_rst_n = 1'b0; b_en = 1'b0; b_sv = 1'b0; b_seed = '0; b_req = '0;

        // Expected words are hand-stepped from 4575: 8AEA 95D1 ABA7 D74B 2E93 5D26 BA4C F49D 693F ...
        vecs[0]  = mk(1, 0, 16'h0000, 4'b0001, 4'b0001, 1, 16'h4575, 16'd1);
        vecs[1]  = mk(1, 0, 16'h0000, 4'b0001, 4'b0001, 1, 16'h8AEA, 16'd2);
        vecs[2]  = mk(1, 0, 16'h0000, 4'b0001, 4'b0001, 1, 16'h95D1, 16'd3);
        vecs[3]  = mk(1, 0, 16'h0000, 4'b1111, 4'b0010, 1, 16'hABA7, 16'd4);
        vecs[4]  = mk(1, 0, 16'h0000, 4'b1111, 4'b0100, 1, 16'hD74B, 16'd5);
        vecs[5]  = mk(1, 0, 16'h0000, 4'b1111, 4'b1000, 1, 16'h2E93, 16'd6);
        vecs[6]  = mk(1, 0, 16'h0000, 4'b1111, 4'b0001, 1, 16'h5D26, 16'd7);
        vecs[7]  = mk(1, 0, 16'h0000, 4'b0010, 4'b0010, 1, 16'hBA4C, 16'd8);
        vecs[8]  = mk(0, 0, 16'h0000, 4'b0010, 4'b0000, 0, 16'hBA4C, 16'd8);
        vecs[9]  = mk(0, 0, 16'h0000, 4'b0010, 4'b0000, 0, 16'hBA4C, 16'd8);
        vecs[10] = mk(0, 0, 16'h0000, 4'b0010, 4'b0000, 0, 16'hBA4C, 16'd8);
        vecs[11] = mk(0, 0, 16'h0000, 4'b0010, 4'b0000, 0, 16'hBA4C, 16'd8);
        vecs[12] = mk(0, 0, 16'h0000, 4'b0010, 4'b0000, 0, 16'hBA4C, 16'd8);
        vecs[13] = mk(1, 0, 16'h0000, 4'b0010, 4'b0010, 1, 16'hF49D, 16'd9);
        vecs[14] = mk(1, 0, 16'h0000, 4'b0000, 4'b0000, 0, 16'hF49D, 16'd9);
        vecs[15] = mk(1, 1, 16'h0001, 4'b1111, 4'b0000, 0, 16'hF49D, 16'd9);
        vecs[16] = mk(1, 0, 16'h0000, 4'b1111, 4'b0100, 1, 16'h0001, 16'd10);
        vecs[17] = mk(1, 0, 16'h0000, 4'b0001, 4'b0001, 1, 16'h0002, 16'd11);
        vecs[18] = mk(1, 1, 16'h0000, 4'b0001, 4'b0000, 0, 16'h0002, 16'd11);
        vecs[19] = mk(1, 0, 16'h0000, 4'b0001, 4'b0001, 1, 16'h4575, 16'd12);
        vecs[20] = mk(0, 1, 16'h0001, 4'b0001, 4'b0000, 0, 16'h4575, 16'd12);
        vecs[21] = mk(1, 0, 16'h0000, 4'b0100, 4'b0100, 1, 16'h0001, 16'd13);

        repeat (2) @(negedge clk);
        check("a_rst_grant",  32'(a_grant),  32'h0);
        check("a_rst_valid",  32'(a_valid),  32'h0);
        check("a_rst_data",   32'(a_data),   32'h0);
        check("a_rst_served", 32'(a_served), 32'h0);
        check("a_rst_busy",   32'(a_busy),   32'h0);
        check("b_rst_busy",   32'(b_busy),   32'h1);

        // Instance A: vector table, one vector per clock
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            a_rst_n = 1'b1;
            a_en = vecs[i].en; a_sv = vecs[i].sv; a_seed = vecs[i].seed; a_req = vecs[i].req;
            @(posedge clk); #1;
            check($sformatf("a_v%0d_grant", i),  32'(a_grant),  32'(vecs[i].grant));
            check($sformatf("a_v%0d_valid", i),  32'(a_valid),  32'(vecs[i].valid));
            check($sformatf("a_v%0d_data", i),   32'(a_data),   32'(vecs[i].data));
            check($sformatf("a_v%0d_served", i), 32'(a_served), 32'(vecs[i].served));
            check($sformatf("a_v%0d_busy", i),   32'(a_busy),   32'h0);
        end

        // Instance A: reset asserted mid-SERVE clears outputs at once, and the pointer restarts at requester 0
        @(negedge clk);
        a_sv = 1'b0; a_en = 1'b1; a_req = 4'b1111;
        a_rst_n = 1'b0;
        #1;
        check("a_midrst_grant",  32'(a_grant),  32'h0);
        check("a_midrst_valid",  32'(a_valid),  32'h0);
        check("a_midrst_data",   32'(a_data),   32'h0);
        check("a_midrst_served", 32'(a_served), 32'h0);
        @(negedge clk);
        a_rst_n = 1'b1;
        @(posedge clk); #1;
        check("a_post_grant",  32'(a_grant),  32'h1);
        check("a_post_data",   32'(a_data),   32'h4575);
        check("a_post_served", 32'(a_served), 32'h1);
        @(negedge clk);
        a_en = 1'b0; a_req = '0;

        // Instance B: busy for 16 enabled cycles (reset plus 15 steps), then the first grant carries step^16(4575)
        b_rst_n = 1'b1; b_en = 1'b1; b_req = 4'b1111;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            check($sformatf("b_warm%0d_busy", k),  32'(b_busy),  32'h1);
            check($sformatf("b_warm%0d_valid", k), 32'(b_valid), 32'h0);
        end
        @(posedge clk); #1;
        check("b_warm16_busy",  32'(b_busy),  32'h0);
        check("b_warm16_valid", 32'(b_valid), 32'h0);
        @(posedge clk); #1;
        check("b_g1_grant",  32'(b_grant),  32'h1);
        check("b_g1_valid",  32'(b_valid),  32'h1);
        check("b_g1_data",   32'(b_data),   32'h1F3B);
        check("b_g1_served", 32'(b_served), 32'h1);
        @(posedge clk); #1;
        check("b_g2_grant", 32'(b_grant), 32'h2);
        check("b_g2_data",  32'(b_data),  32'h3E76);

        // Instance B: a seed load while requests are active suppresses that grant and restarts warm-up
        @(negedge clk);
        b_sv = 1'b1; b_seed = 16'h0001;
        @(posedge clk); #1;
        check("b_seed_valid", 32'(b_valid), 32'h0);
        check("b_seed_busy",  32'(b_busy),  32'h1);
        @(negedge clk);
        b_sv = 1'b0; b_seed = '0;
        for (int k = 2; k <= 15; k++) begin
            @(posedge clk); #1;
            check($sformatf("b_rewarm%0d_busy", k),  32'(b_busy),  32'h1);
            check($sformatf("b_rewarm%0d_valid", k), 32'(b_valid), 32'h0);
        end
        @(posedge clk); #1;
        check("b_rewarm16_busy", 32'(b_busy), 32'h1);
        @(posedge clk); #1;
        check("b_rewarm_end_busy", 32'(b_busy), 32'h0);
        @(posedge clk); #1;
        check("b_rg_grant",  32'(b_grant),  32'h4);
        check("b_rg_valid",  32'(b_valid),  32'h1);
        check("b_rg_data",   32'(b_data),   32'h8005);
        check("b_rg_served", 32'(b_served), 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
